// File: rtl/fb_pkg.sv
// Framebuffer geometry and writer state encoding,
// shared by the pixel writer and the panel display driver.
package fb_pkg;

    localparam int H_LEN     = 64;
    localparam int V_LEN     = 64;
    localparam int HALF_ROWS = V_LEN / 2;

    localparam int X_W    = 6;
    localparam int Y_W    = 6;
    localparam int CNT_W  = X_W + Y_W;
    localparam int ROW_W  = Y_W - 1;
    localparam int ADDR_W = 1 + ROW_W + X_W;
    localparam int RGB_W  = 24;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } fb_state_t;

    // Both panel halves share one RAM word; the row-within-half picks it.
    function automatic logic [ADDR_W-1:0] fb_addr(
        input logic             bank,
        input logic [ROW_W-1:0] row,
        input logic [X_W-1:0]   x
    );
        return {bank, row, x};
    endfunction

    function automatic logic [1:0] fb_lane(input logic lower_half);
        return lower_half ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fb_pixel_counter.sv
// Raster position counter: loads 1 on start-of-frame, wraps after
// the last pixel, and decodes the current beat into x/row/half.
module fb_pixel_counter
    import fb_pkg::*;
#(
    parameter int H_LEN = fb_pkg::H_LEN,
    parameter int V_LEN = fb_pkg::V_LEN
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_advance,
    input  logic             i_sof,
    output logic [CNT_W-1:0] o_cnt,
    output logic [X_W-1:0]   o_x,
    output logic [ROW_W-1:0] o_row,
    output logic             o_half,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(H_LEN * V_LEN - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] idx;

    // A start-of-frame beat is always pixel 0, whatever the count says.
    always_comb begin
        idx = i_sof ? '0 : cnt;
    end

    assign o_cnt  = cnt;
    assign o_x    = idx[X_W-1:0];
    assign o_row  = idx[CNT_W-2:X_W];
    assign o_half = idx[CNT_W-1];
    assign o_last = !i_sof && (cnt == LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (i_advance) begin
            if (i_sof)
                cnt <= CNT_W'(1);
            else if (o_last)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Streams raster pixels into the back bank of a double-buffered
// HUB75 framebuffer and swaps banks when the display wraps.
module fb_writer
    import fb_pkg::*;
#(
    parameter int H_LEN = fb_pkg::H_LEN,
    parameter int V_LEN = fb_pkg::V_LEN
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic [RGB_W-1:0]  i_rgb,
    output logic              o_ready,
    input  logic              i_frame_done,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [1:0]        o_wr_be,
    output logic [RGB_W-1:0]  o_wr_data,
    output logic              o_disp_bank,
    output logic              o_frame_err
);

    fb_state_t state;

    logic             accept;
    logic             wr_fire;
    logic             resync;
    logic [CNT_W-1:0] cnt;
    logic [X_W-1:0]   px_x;
    logic [ROW_W-1:0] px_row;
    logic             px_half;
    logic             px_last;

    assign o_ready = (state != ST_WAIT_SWAP);
    assign accept  = i_valid && o_ready;

    // Outside a frame only a start-of-frame beat is worth keeping.
    always_comb begin
        wr_fire = 1'b0;
        resync  = 1'b0;
        if (accept) begin
            wr_fire = (state == ST_WRITE) || i_sof;
            resync  = (state == ST_WRITE) && i_sof;
        end
    end

    fb_pixel_counter #(
        .H_LEN (H_LEN),
        .V_LEN (V_LEN)
    ) u_cnt (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_advance (wr_fire),
        .i_sof     (i_sof),
        .o_cnt     (cnt),
        .o_x       (px_x),
        .o_row     (px_row),
        .o_half    (px_half),
        .o_last    (px_last)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            o_disp_bank <= 1'b0;
            o_we        <= 1'b0;
            o_wr_be     <= 2'b00;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_we        <= wr_fire;
            o_wr_be     <= wr_fire ? fb_lane(px_half) : 2'b00;
            o_frame_err <= resync;
            if (wr_fire) begin
                o_wr_addr <= fb_addr(~o_disp_bank, px_row, px_x);
                o_wr_data <= i_rgb;
            end
            unique case (state)
                ST_IDLE: begin
                    if (wr_fire)
                        state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_fire && px_last)
                        state <= ST_WAIT_SWAP;
                end
                ST_WAIT_SWAP: begin
                    if (i_frame_done) begin
                        o_disp_bank <= ~o_disp_bank;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: frame fill, bank swap, framing
// errors, ignored frame_done pulses and mid-frame reset.
module tb_fb_writer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_sof = 1'b0;
    logic        i_frame_done = 1'b0;
    logic [23:0] i_rgb = '0;
    logic        o_ready;
    logic        o_we;
    logic [11:0] o_wr_addr;
    logic [1:0]  o_wr_be;
    logic [23:0] o_wr_data;
    logic        o_disp_bank;
    logic        o_frame_err;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int b0_count = 0;
    int b1_count = 0;
    int err_pulses = 0;

    fb_writer dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .i_rgb        (i_rgb),
        .o_ready      (o_ready),
        .i_frame_done (i_frame_done),
        .o_we         (o_we),
        .o_wr_addr    (o_wr_addr),
        .o_wr_be      (o_wr_be),
        .o_wr_data    (o_wr_data),
        .o_disp_bank  (o_disp_bank),
        .o_frame_err  (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_we) begin
            wr_count++;
            if (o_wr_addr[11]) b1_count++;
            else b0_count++;
        end
        if (o_frame_err) err_pulses++;
    end

    function automatic logic [23:0] pix(input int i);
        logic [11:0] v;
        v = 12'(i);
        return {v[7:0], v[11:4], 8'h5A};
    endfunction

    function automatic logic [11:0] exp_addr(input logic bank, input int i);
        logic [11:0] v;
        v = 12'(i);
        return {bank, v[10:6], v[5:0]};
    endfunction

    function automatic logic [1:0] exp_be(input int i);
        logic [11:0] v;
        v = 12'(i);
        return v[11] ? 2'b10 : 2'b01;
    endfunction

    task automatic cyc(input logic v, input logic s,
                       input logic [23:0] rgb, input logic fd);
        i_valid = v;
        i_sof = s;
        i_rgb = rgb;
        i_frame_done = fd;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_sof = 1'b0;
        i_frame_done = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_sof = 1'b0;
        i_frame_done = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        #2;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", o_ready);
        end
        checks++;
        if (o_we !== 1'b0 || o_wr_be !== 2'b00) begin
            errors++; $display("FAIL reset_we got we=%b be=%b want 0/00", o_we, o_wr_be);
        end
        checks++;
        if (o_wr_addr !== 12'h000 || o_wr_data !== 24'h0) begin
            errors++; $display("FAIL reset_wr got %h/%h want 000/000000", o_wr_addr, o_wr_data);
        end
        checks++;
        if (o_disp_bank !== 1'b0 || o_frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_bank got bank=%b err=%b want 0/0", o_disp_bank, o_frame_err);
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        int w0;
        do_reset();
        w0 = wr_count;
        for (int i = 0; i < 4096; i++) begin
            cyc(1'b1, i == 0, pix(i), 1'b0);
            checks++;
            if (o_we !== 1'b1 || o_wr_addr !== exp_addr(1'b1, i) ||
                o_wr_be !== exp_be(i) || o_wr_data !== pix(i)) begin
                errors++;
                $display("FAIL frame_beat %0d got we=%b a=%h be=%b d=%h want 1 a=%h be=%b d=%h",
                         i, o_we, o_wr_addr, o_wr_be, o_wr_data,
                         exp_addr(1'b1, i), exp_be(i), pix(i));
            end
            if (i == 2047) begin
                checks++;
                if (o_wr_addr !== 12'hFFF || o_wr_be !== 2'b01) begin
                    errors++; $display("FAIL beat2047 got %h/%b want FFF/01", o_wr_addr, o_wr_be);
                end
            end
            if (i == 2048) begin
                checks++;
                if (o_wr_addr !== 12'h800 || o_wr_be !== 2'b10) begin
                    errors++; $display("FAIL beat2048 got %h/%b want 800/10", o_wr_addr, o_wr_be);
                end
            end
            if (i == 4094) begin
                checks++;
                if (o_ready !== 1'b1) begin
                    errors++; $display("FAIL ready_4094 got %b want 1", o_ready);
                end
            end
        end
        checks++;
        if (o_ready !== 1'b0) begin
            errors++; $display("FAIL ready_after_last got %b want 0", o_ready);
        end
        cyc(1'b1, 1'b0, 24'h123456, 1'b0);
        checks++;
        if (o_we !== 1'b0 || o_ready !== 1'b0) begin
            errors++; $display("FAIL wait_swap_hold got we=%b rdy=%b want 0/0", o_we, o_ready);
        end
        checks++;
        if (wr_count - w0 !== 4096) begin
            errors++; $display("FAIL frame_writes got %0d want 4096", wr_count - w0);
        end
    endtask

    task automatic test_swap();
        cyc(1'b0, 1'b0, 24'h0, 1'b1);
        checks++;
        if (o_disp_bank !== 1'b1 || o_ready !== 1'b1) begin
            errors++; $display("FAIL swap got bank=%b rdy=%b want 1/1", o_disp_bank, o_ready);
        end
        cyc(1'b1, 1'b1, pix(7), 1'b0);
        checks++;
        if (o_we !== 1'b1 || o_wr_addr !== 12'h000 || o_wr_be !== 2'b01 ||
            o_wr_data !== pix(7)) begin
            errors++;
            $display("FAIL swap_first got we=%b a=%h be=%b d=%h want 1/000/01/%h",
                     o_we, o_wr_addr, o_wr_be, o_wr_data, pix(7));
        end
    endtask

    task automatic test_idle_drop();
        int w0;
        do_reset();
        w0 = wr_count;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, pix(i + 50), 1'b0);
            checks++;
            if (o_we !== 1'b0 || o_ready !== 1'b1) begin
                errors++; $display("FAIL idle_drop %0d got we=%b rdy=%b want 0/1", i, o_we, o_ready);
            end
        end
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        checks++;
        if (wr_count !== w0) begin
            errors++; $display("FAIL idle_writes got %0d want %0d", wr_count, w0);
        end
        cyc(1'b1, 1'b1, pix(0), 1'b0);
        checks++;
        if (o_we !== 1'b1 || o_wr_addr !== 12'h800 || o_wr_be !== 2'b01) begin
            errors++; $display("FAIL idle_sof got we=%b a=%h be=%b want 1/800/01", o_we, o_wr_addr, o_wr_be);
        end
        cyc(1'b1, 1'b0, pix(1), 1'b0);
        checks++;
        if (o_wr_addr !== 12'h801) begin
            errors++; $display("FAIL idle_next got %h want 801", o_wr_addr);
        end
    endtask

    task automatic test_frame_err();
        int e0;
        do_reset();
        e0 = err_pulses;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, i == 0, pix(i), 1'b0);
        end
        checks++;
        if (o_frame_err !== 1'b0 || o_wr_addr !== 12'h863) begin
            errors++; $display("FAIL err_before got err=%b a=%h want 0/863", o_frame_err, o_wr_addr);
        end
        cyc(1'b1, 1'b1, pix(100), 1'b0);
        checks++;
        if (o_frame_err !== 1'b1 || o_wr_addr !== 12'h800 || o_wr_be !== 2'b01 ||
            o_wr_data !== pix(100)) begin
            errors++;
            $display("FAIL err_pulse got err=%b a=%h be=%b d=%h want 1/800/01/%h",
                     o_frame_err, o_wr_addr, o_wr_be, o_wr_data, pix(100));
        end
        for (int k = 1; k < 4096; k++) begin
            cyc(1'b1, 1'b0, pix(k), 1'b0);
            if (k == 1) begin
                checks++;
                if (o_frame_err !== 1'b0 || o_wr_addr !== 12'h801) begin
                    errors++; $display("FAIL err_after got err=%b a=%h want 0/801", o_frame_err, o_wr_addr);
                end
            end
            if (k == 4094) begin
                checks++;
                if (o_ready !== 1'b1) begin
                    errors++; $display("FAIL err_ready_4094 got %b want 1", o_ready);
                end
            end
        end
        checks++;
        if (o_ready !== 1'b0 || o_wr_addr !== 12'hFFF || o_wr_be !== 2'b10) begin
            errors++; $display("FAIL err_last got rdy=%b a=%h be=%b want 0/FFF/10", o_ready, o_wr_addr, o_wr_be);
        end
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        checks++;
        if (err_pulses - e0 !== 1 || o_disp_bank !== 1'b0) begin
            errors++; $display("FAIL err_count got %0d bank=%b want 1/0", err_pulses - e0, o_disp_bank);
        end
    endtask

    task automatic test_done_ignored();
        do_reset();
        for (int i = 0; i < 4096; i++) begin
            cyc(1'b1, i == 0, pix(i), (i == 10) || (i == 4095));
            if (i == 10) begin
                checks++;
                if (o_disp_bank !== 1'b0) begin
                    errors++; $display("FAIL done_in_write got bank %b want 0", o_disp_bank);
                end
            end
        end
        checks++;
        if (o_disp_bank !== 1'b0 || o_ready !== 1'b0) begin
            errors++; $display("FAIL done_on_last got bank=%b rdy=%b want 0/0", o_disp_bank, o_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 24'h0, 1'b0);
            checks++;
            if (o_disp_bank !== 1'b0 || o_ready !== 1'b0) begin
                errors++; $display("FAIL done_wait %0d got bank=%b rdy=%b want 0/0", i, o_disp_bank, o_ready);
            end
        end
        cyc(1'b0, 1'b0, 24'h0, 1'b1);
        checks++;
        if (o_disp_bank !== 1'b1 || o_ready !== 1'b1) begin
            errors++; $display("FAIL done_late got bank=%b rdy=%b want 1/1", o_disp_bank, o_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        int b0;
        int w0;
        int n;
        do_reset();
        b0 = b0_count;
        n = 0;
        while (n < 1000) begin
            repeat ($urandom_range(0, 2)) begin
                cyc(1'b0, 1'b0, 24'h0, 1'b0);
                checks++;
                if (o_we !== 1'b0) begin
                    errors++; $display("FAIL gap_we got %b want 0", o_we);
                end
            end
            cyc(1'b1, n == 0, pix(n), 1'b0);
            checks++;
            if (o_we !== 1'b1 || o_wr_addr !== exp_addr(1'b1, n)) begin
                errors++; $display("FAIL gap_beat %0d got we=%b a=%h want 1/%h",
                                   n, o_we, o_wr_addr, exp_addr(1'b1, n));
            end
            n++;
        end
        i_valid = 1'b1;
        #2;
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_we !== 1'b0 || o_wr_be !== 2'b00 || o_wr_addr !== 12'h000 ||
            o_wr_data !== 24'h0 || o_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got we=%b be=%b a=%h d=%h err=%b want zeros",
                     o_we, o_wr_be, o_wr_addr, o_wr_data, o_frame_err);
        end
        checks++;
        if (o_ready !== 1'b1 || o_disp_bank !== 1'b0) begin
            errors++; $display("FAIL async_reset_rdy got rdy=%b bank=%b want 1/0", o_ready, o_disp_bank);
        end
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        w0 = wr_count;
        cyc(1'b1, 1'b0, pix(1001), 1'b0);
        checks++;
        if (o_we !== 1'b0) begin
            errors++; $display("FAIL post_reset_nosof got we %b want 0", o_we);
        end
        n = 0;
        while (n < 4096) begin
            repeat ($urandom_range(0, 1)) cyc(1'b0, 1'b0, 24'h0, 1'b0);
            cyc(1'b1, n == 0, pix(n), 1'b0);
            checks++;
            if (o_we !== 1'b1 || o_wr_addr !== exp_addr(1'b1, n) || o_wr_be !== exp_be(n)) begin
                errors++; $display("FAIL post_reset_beat %0d got we=%b a=%h be=%b want 1/%h/%b",
                                   n, o_we, o_wr_addr, o_wr_be, exp_addr(1'b1, n), exp_be(n));
            end
            n++;
        end
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        checks++;
        if (wr_count - w0 !== 4096 || b0_count !== b0 || o_ready !== 1'b0) begin
            errors++; $display("FAIL post_reset_frame got w=%0d b0=%0d rdy=%b want 4096/0/0",
                               wr_count - w0, b0_count - b0, o_ready);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_swap();
        test_idle_drop();
        test_frame_err();
        test_done_ignored();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
